// File: rtl/l2_data_pkg.sv
// Shared types and width helpers for the banked L2 data array.
// Optional feature macro used by this slice: L2_DATA_BYPASS_EN (read-during-write forwarding).
package l2_data_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   localparam int DEF_S_OFFSET = 5;
   localparam int DEF_S_INDEX  = 3;
   localparam int DEF_NUM_WAYS = 4;

   function automatic int mask_bits(input int s_offset);
      return 2 ** s_offset;
   endfunction

   function automatic int line_bits(input int s_offset);
      return 8 * (2 ** s_offset);
   endfunction

   // A single-way build still needs a 1-bit way select.
   function automatic int way_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/l2_data_bank.sv
// One way of the L2 data array: num_sets lines, byte-masked write, registered read.
// With L2_DATA_BYPASS_EN defined, a same-set write is forwarded into the read result byte by byte.
module l2_data_bank
   import l2_data_pkg::*;
#(
   parameter  int s_offset = DEF_S_OFFSET,
   parameter  int s_index  = DEF_S_INDEX,
   localparam int s_mask   = mask_bits(s_offset),
   localparam int s_line   = line_bits(s_offset)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [s_mask-1:0] i_we,
   input  logic [s_index-1:0] i_waddr,
   input  logic [s_line-1:0] i_wdata,
   input  logic              i_re,
   input  logic [s_index-1:0] i_raddr,
   output logic [s_line-1:0] o_rdata
);

   localparam int num_sets = 2 ** s_index;

   logic [s_line-1:0] r_mem [num_sets];
   logic [s_line-1:0] r_rdata;
   logic [s_line-1:0] w_rd_line;

   // NOTE: the storage array has no reset; the INIT sweep of the parent clears it, which keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      for (int i = 0; i < s_mask; i++) begin
         if (i_we[i]) begin
            r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
   end

   // NOTE: every variable driven here gets a default first so no latch can be inferred.
   always_comb begin
      w_rd_line = r_mem[i_raddr];
`ifdef L2_DATA_BYPASS_EN
      if (i_waddr == i_raddr) begin
         for (int i = 0; i < s_mask; i++) begin
            if (i_we[i]) begin
               w_rd_line[8*i +: 8] = i_wdata[8*i +: 8];
            end
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= w_rd_line;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/l2_banked_data_array.sv
// Banked L2 data array: num_ways single-way banks, zero-fill INIT sweep after reset, 1-cycle reads.
// Build option L2_DATA_BYPASS_EN selects write-to-read forwarding on a same-cycle hit.
module l2_banked_data_array
   import l2_data_pkg::*;
#(
   parameter  int s_offset = DEF_S_OFFSET,
   parameter  int s_index  = DEF_S_INDEX,
   parameter  int num_ways = DEF_NUM_WAYS,
   localparam int s_mask   = mask_bits(s_offset),
   localparam int s_line   = line_bits(s_offset),
   localparam int s_way    = way_bits(num_ways)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               read,
   input  logic [s_index-1:0] rindex,
   input  logic [s_way-1:0]   rway,
   input  logic [s_mask-1:0]  write_en,
   input  logic [s_index-1:0] windex,
   input  logic [s_way-1:0]   wway,
   input  logic [s_line-1:0]  datain,
   output logic [s_line-1:0]  dataout,
   output logic               dout_valid,
   output logic               ready
);

   localparam int num_sets = 2 ** s_index;
   localparam logic [s_index:0] LAST_SET  = (s_index+1)'(num_sets - 1);
   localparam logic [s_way:0]   WAY_LIMIT = (s_way+1)'(num_ways);

   state_e             r_state;
   logic [s_index:0]   r_init_cnt;
   logic               r_dout_valid;
   logic [s_way-1:0]   r_rd_way;
   logic               r_rd_oob;

   logic               w_init;
   logic               w_rd_accept;
   logic               w_rd_oob;
   logic [s_index-1:0] w_waddr;
   logic [s_line-1:0]  w_wdata;
   logic [s_line-1:0]  w_bank_rdata [num_ways];

   assign w_init      = (r_state == INIT);
   assign w_rd_accept = (r_state == READY) && read;
   assign w_rd_oob    = ({1'b0, rway} >= WAY_LIMIT);
   assign w_waddr     = w_init ? r_init_cnt[s_index-1:0] : windex;
   assign w_wdata     = w_init ? '0 : datain;

   for (genvar g = 0; g < num_ways; g++) begin : g_way
      localparam logic [s_way-1:0] WAY_ID = s_way'(g);
      logic [s_mask-1:0] w_we;
      logic              w_re;

      // INIT clears every way of the current set at once.
      assign w_we = w_init ? '1 : ((wway == WAY_ID) ? write_en : '0);
      assign w_re = w_rd_accept && (rway == WAY_ID);

      l2_data_bank #(
         .s_offset (s_offset),
         .s_index  (s_index)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .i_we    (w_we),
         .i_waddr (w_waddr),
         .i_wdata (w_wdata),
         .i_re    (w_re),
         .i_raddr (rindex),
         .o_rdata (w_bank_rdata[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= INIT;
         r_init_cnt   <= '0;
         r_dout_valid <= 1'b0;
         r_rd_way     <= '0;
         r_rd_oob     <= 1'b0;
      end else begin
         r_dout_valid <= w_rd_accept;
         if (w_rd_accept) begin
            r_rd_way <= rway;
            r_rd_oob <= w_rd_oob;
         end
         case (r_state)
            INIT: begin
               r_init_cnt <= r_init_cnt + 1'b1;
               if (r_init_cnt == LAST_SET) begin
                  r_state <= READY;
               end
            end
            READY:   r_state <= READY;
            default: r_state <= INIT;
         endcase
      end
   end

   // Each bank holds its own last result, so the held way select keeps dataout stable between reads.
   always_comb begin
      dataout = '0;
      if (!r_rd_oob) begin
         dataout = w_bank_rdata[r_rd_way];
      end
   end

   assign dout_valid = r_dout_valid;
   assign ready      = (r_state == READY);

endmodule

// File: tb/tb_l2_banked_data_array.sv
// Directed bench for l2_banked_data_array at default parameters; expectations follow L2_DATA_BYPASS_EN.
module tb_l2_banked_data_array;

   logic         clk = 1'b0;
   logic         rst;
   logic         read;
   logic [2:0]   rindex;
   logic [1:0]   rway;
   logic [31:0]  write_en;
   logic [2:0]   windex;
   logic [1:0]   wway;
   logic [255:0] datain;
   logic [255:0] dataout;
   logic         dout_valid;
   logic         ready;

   int n_vec = 0;
   int n_err = 0;

   l2_banked_data_array dut (
      .clk        (clk),
      .rst        (rst),
      .read       (read),
      .rindex     (rindex),
      .rway       (rway),
      .write_en   (write_en),
      .windex     (windex),
      .wway       (wway),
      .datain     (datain),
      .dataout    (dataout),
      .dout_valid (dout_valid),
      .ready      (ready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Counts cycles with ready=0 from the current observation until ready rises (bounded).
   task automatic count_init(input string tag);
      int n = 0;
      int bad_valid = 0;
      while (!ready && n < 50) begin
         if (dout_valid !== 1'b0) bad_valid++;
         n++;
         tick();
      end
      check({tag, "_ready_low_cycles"}, 256'(n), 256'(8));
      check({tag, "_no_valid_in_init"}, 256'(bad_valid), 256'(0));
      check({tag, "_ready_high"}, 256'(ready), 256'(1));
   endtask

   task automatic do_read(input logic [2:0] idx, input logic [1:0] way);
      read   = 1'b1;
      rindex = idx;
      rway   = way;
      tick();
      read   = 1'b0;
   endtask

   logic [255:0] l_a5;
   logic [255:0] l_after_3c;
   logic [255:0] l_after_ff;
   logic [255:0] l_5a;
   logic [255:0] l_11;
   logic [255:0] l_hit_exp;

   initial begin
      l_a5       = {32{8'hA5}};
      l_after_3c = {{31{8'hA5}}, 8'h3C};
      l_after_ff = {{28{8'hA5}}, 32'hFFFF_FFFF};
      l_5a       = {32{8'h5A}};
      l_11       = {32{8'h11}};
`ifdef L2_DATA_BYPASS_EN
      l_hit_exp  = l_after_ff;
`else
      l_hit_exp  = l_after_3c;
`endif

      rst = 1'b1; read = 1'b0; rindex = '0; rway = '0;
      write_en = '0; windex = '0; wway = '0; datain = '0;

      // Reset state, then the INIT sweep lasts exactly 8 cycles.
      tick();
      check("rst_ready", 256'(ready), 256'(0));
      check("rst_valid", 256'(dout_valid), 256'(0));
      check("rst_dataout", dataout, '0);
      rst = 1'b0;
      count_init("init1");

      do_read(3'd5, 2'd2);
      check("rd52_valid", 256'(dout_valid), 256'(1));
      check("rd52_data", dataout, '0);
      tick();
      check("idle_valid", 256'(dout_valid), 256'(0));

      // Full-line write then read.
      write_en = '1; windex = 3'd3; wway = 2'd1; datain = l_a5;
      tick();
      write_en = '0;
      do_read(3'd3, 2'd1);
      check("a5_valid", 256'(dout_valid), 256'(1));
      check("a5_data", dataout, l_a5);

      // Single-byte write; other datain bytes are zero and must not land.
      write_en = 32'h0000_0001; datain = {{31{8'h00}}, 8'h3C};
      tick();
      write_en = '0;
      do_read(3'd3, 2'd1);
      check("byte0_data", dataout, l_after_3c);

      // Same-cycle read/write hit on set 3 way 1.
      write_en = 32'h0000_000F; datain = {32{8'hFF}}; windex = 3'd3; wway = 2'd1;
      do_read(3'd3, 2'd1);
      write_en = '0;
      check("hit_valid", 256'(dout_valid), 256'(1));
      check("hit_data", dataout, l_hit_exp);
      do_read(3'd3, 2'd1);
      check("hit_landed", dataout, l_after_ff);

      // Same-cycle write to a different way of the same set: read sees pre-existing data.
      write_en = '1; datain = l_11; windex = 3'd3; wway = 2'd2;
      do_read(3'd3, 2'd1);
      write_en = '0;
      check("diff_way_rd", dataout, l_after_ff);
      do_read(3'd3, 2'd2);
      check("diff_way_wr", dataout, l_11);

      // Fill set 7 way 3, then a write_en=0 cycle with other data is a no-op.
      write_en = '1; windex = 3'd7; wway = 2'd3; datain = l_5a;
      tick();
      write_en = '0; datain = {32{8'hEE}};
      tick();

      // Back-to-back reads, no bubble, then dataout holds.
      do_read(3'd0, 2'd0);
      check("b2b0_valid", 256'(dout_valid), 256'(1));
      check("b2b0_data", dataout, '0);
      do_read(3'd7, 2'd3);
      check("b2b1_valid", 256'(dout_valid), 256'(1));
      check("b2b1_data", dataout, l_5a);
      tick();
      check("hold_valid", 256'(dout_valid), 256'(0));
      check("hold_data", dataout, l_5a);

      // Reset during a read aborts it; reset again in INIT cycle 4 restarts the sweep.
      read = 1'b1; rindex = 3'd7; rway = 2'd3; rst = 1'b1;
      tick();
      check("rst_rd_valid", 256'(dout_valid), 256'(0));
      check("rst_rd_data", dataout, '0);
      rst = 1'b0;
      write_en = '1; windex = 3'd7; wway = 2'd3; datain = {32{8'h77}};
      repeat (4) tick();
      check("mid_init_ready", 256'(ready), 256'(0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      count_init("init2");
      read = 1'b0; write_en = '0;

      do_read(3'd3, 2'd1);
      check("clr_s3w1", dataout, '0);
      do_read(3'd7, 2'd3);
      check("clr_s7w3", dataout, '0);
      do_read(3'd3, 2'd2);
      check("clr_s3w2", dataout, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/l2_banked_data_array.md
L2_BANKED_DATA_ARRAY -- requirements
Module: l2_banked_data_array

Interface
REQ-001 SHALL take parameter s_offset, default 5, log2 of line bytes (s_mask=2**s_offset, s_line=8*s_mask).
REQ-002 SHALL take parameter s_index, default 3, log2 of set count (num_sets=2**s_index).
REQ-003 SHALL take parameter num_ways, default 4, ways per set (s_way=$clog2(num_ways), minimum 1 bit).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port read  input  1  read request, sampled when ready=1.
REQ-007 SHALL have port rindex  input  s_index  read set.
REQ-008 SHALL have port rway  input  s_way  read way.
REQ-009 SHALL have port write_en  input  s_mask  per-byte write enable, bit i covers datain[8*i +: 8].
REQ-010 SHALL have port windex  input  s_index  write set.
REQ-011 SHALL have port wway  input  s_way  write way.
REQ-012 SHALL have port datain  input  s_line  write data.
REQ-013 SHALL have port dataout  output  s_line  registered read data.
REQ-014 SHALL have port dout_valid  output  1  one-cycle pulse, dataout holds new read result.
REQ-015 SHALL have port ready  output  1  array accepts read/write this cycle.

Function
REQ-016 SHALL implement states INIT and READY; rst forces INIT with init counter 0.
REQ-017 In INIT SHALL write all-zero to every way of set init_cnt each cycle, increment init_cnt, and go to READY after writing set num_sets-1 (exactly num_sets cycles after rst deasserts).
REQ-018 In INIT SHALL hold ready=0 and ignore read and write_en entirely.
REQ-019 In READY SHALL hold ready=1 and remain there until rst.
REQ-020 Read accepted (ready&read) at edge N SHALL present data at dataout with dout_valid=1 after edge N+1 (1-cycle latency), one result per cycle, back-to-back allowed.
REQ-021 dout_valid SHALL be 0 in cycles without an accepted read; dataout SHALL hold its last value then.
REQ-022 Write in READY SHALL update only bytes with write_en[i]=1 at (windex,wway) at the edge; write_en=0 SHALL be a no-op.
REQ-023 Read and write in the same cycle to different set or way SHALL both complete; read returns pre-existing data.
REQ-024 Same-cycle read/write to identical (index,way) SHALL follow REQ-031/REQ-032.
REQ-025 Index and way arithmetic SHALL be unsigned; rway/wway >= num_ways SHALL not modify storage and SHALL read zero.
REQ-026 init_cnt SHALL be s_index+1 bits wide so the terminal compare does not alias on wrap.

Reset
REQ-027 On rst SHALL set dataout=0, dout_valid=0, ready=0, state=INIT, init_cnt=0.
REQ-028 rst asserted mid-INIT or mid-read SHALL abort the operation (no dout_valid pulse) and restart the full INIT sweep.
REQ-029 Storage content after INIT completion SHALL be all zeros regardless of prior content.

Configuration
REQ-030 SHALL use macro L2_DATA_BYPASS_EN.
REQ-031 With L2_DATA_BYPASS_EN defined, same-cycle read/write hit SHALL return datain for enabled bytes and stored data for others.
REQ-032 Without it, same-cycle read/write hit SHALL return the old stored line; the write still lands.

Structure
REQ-033 Package l2_data_pkg SHALL hold the state enum (INIT, READY) and line-width/mask helper constants.
REQ-034 Sub-module l2_data_bank SHALL implement one way: num_sets x s_line storage, byte-mask write, synchronous read; instantiated num_ways times by generate.

Verification
REQ-035 rst 1 cycle then release -> ready=0 for exactly 8 cycles (defaults), then 1; read set 5 way 2 -> dataout=0, dout_valid=1 next cycle.
REQ-036 Write all-ones mask, datain=0xA5 repeated, set 3 way 1; read next cycle -> 0xA5 in all 32 bytes after 1 cycle.
REQ-037 Write write_en=0x0000_0001 datain byte0=0x3C to set 3 way 1 then read -> byte0=0x3C, bytes 1-31=0xA5.
REQ-038 Same-cycle write 0xFF bytes0-3 and read set 3 way 1 -> bypass build: bytes0-3=0xFF; non-bypass: old 0x3C/0xA5.
REQ-039 Reads to set 0 way 0 and set 7 way 3 on consecutive cycles -> two consecutive dout_valid pulses with correct data, no bubble.
REQ-040 Assert rst during INIT cycle 4 -> ready stays 0 for 8 further cycles; prior written data reads back 0.
